fp32_mul_pipe: RTL

FP32_MUL_PIPE -- requirements
Module: fp32_mul_pipe

---
 rtl/fpu_pkg.sv | 38 +++
 rtl/fp32_mul_pipe_if.sv | 27 ++
 rtl/fp32_classify.sv | 40 ++++
 rtl/fp32_mul_pipe.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared binary32 definitions: field widths, bias, canonical NaN, flag
// bit positions, operand classes and the unpacked word layout.
package fpu_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned FRAC_W   = 23;
    localparam int unsigned MANT_W   = FRAC_W + 1;        // with hidden bit
    localparam int unsigned MANT_R_W = MANT_W + 1;        // room for rounding carry
    localparam int unsigned PROD_W   = 2 * MANT_W;
    localparam int unsigned EXPI_W   = 10;                // signed exponent intermediate
    localparam int unsigned FLAG_W   = 4;

    localparam int unsigned BIAS = 127;

    localparam logic [WORD_W-1:0] CANON_NAN = 32'h7FC0_0000;

    // rsp_flags = {invalid, overflow, underflow, inexact}
    localparam int unsigned FLAG_INEXACT   = 0;
    localparam int unsigned FLAG_UNDERFLOW = 1;
    localparam int unsigned FLAG_OVERFLOW  = 2;
    localparam int unsigned FLAG_INVALID   = 3;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN
    } fp_class_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  expo;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

endpackage

// File: rtl/fp32_mul_pipe_if.sv
// Request/response handshake bundle for the binary32 multiplier.
//   master: drives req_valid/req_a/req_b/req_id and rsp_ready
//   slave : drives req_ready and rsp_valid/rsp_result/rsp_id/rsp_flags
interface fp32_mul_pipe_if #(
    parameter int unsigned ID_W = 4
);
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_a;
    logic [31:0]     req_b;
    logic [ID_W-1:0] req_id;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_result;
    logic [ID_W-1:0] rsp_id;
    logic [3:0]      rsp_flags;

    modport master (
        output req_valid, req_a, req_b, req_id, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_id, rsp_flags
    );

    modport slave (
        input  req_valid, req_a, req_b, req_id, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_id, rsp_flags
    );
endinterface

// File: rtl/fp32_classify.sv
// Combinational binary32 operand unpack and classification.
//   op     : binary32 operand
//   cls_c  : ZERO (zero or subnormal), NORM, INF, QNAN, SNAN
//   sign_c : sign bit
//   exp_c  : biased exponent field
//   mant_c : mantissa with the hidden bit set
module fp32_classify
    import fpu_pkg::*;
(
    input  logic [WORD_W-1:0] op,
    output fp_class_e         cls_c,
    output logic              sign_c,
    output logic [EXP_W-1:0]  exp_c,
    output logic [MANT_W-1:0] mant_c
);

    fp32_t f;

    assign f = op;

    always_comb begin
        sign_c = f.sign;
        exp_c  = f.expo;
        mant_c = {1'b1, f.frac};
        cls_c  = CLS_NORM;
        if (f.expo == '0) begin
            // subnormals are flushed to zero on input, silently
            cls_c = CLS_ZERO;
        end else if (f.expo == '1) begin
            if (f.frac == '0) begin
                cls_c = CLS_INF;
            end else if (f.frac[FRAC_W-1]) begin
                cls_c = CLS_QNAN;
            end else begin
                cls_c = CLS_SNAN;
            end
        end
    end

endmodule

// File: rtl/fp32_mul_pipe.sv
// Three-stage pipelined binary32 multiplier, round-to-nearest-even,
// flush-to-zero, with valid/ready handshakes on both sides.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of fp32_mul_pipe_if (request in, response out)
// Stages: S1 unpack/classify/24x24 product, S2 normalise/round,
// S3 pack and present.
module fp32_mul_pipe
    import fpu_pkg::*;
#(
    parameter int unsigned ID_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    fp32_mul_pipe_if.slave  bus
);

    localparam logic signed [EXPI_W-1:0] EXP_INF  = EXPI_W'((1 << EXP_W) - 1);
    localparam logic signed [EXPI_W-1:0] EXP_ZERO = '0;

    // stage valid bits and advance conditions
    logic v1, v2, v3;
    logic adv1, adv2, adv3;

    // operand unpack
    fp_class_e         cls_a, cls_b;
    logic              sign_a, sign_b;
    logic [EXP_W-1:0]  exp_a, exp_b;
    logic [MANT_W-1:0] mant_a, mant_b;

    // S1 combinational results
    logic                     spec_c;
    fp32_t                    spec_res_c;
    logic [FLAG_W-1:0]        spec_flags_c;
    logic signed [EXPI_W-1:0] exp_sum_c;
    logic [PROD_W-1:0]        prod_c;
    logic                     sign_c;

    // S1 registers
    logic                     s1_special;
    fp32_t                    s1_spec_res;
    logic [FLAG_W-1:0]        s1_spec_flags;
    logic                     s1_sign;
    logic signed [EXPI_W-1:0] s1_exp;
    logic [PROD_W-1:0]        s1_prod;
    logic [ID_W-1:0]          s1_id;

    // S2 combinational results
    logic                     norm_hi;
    logic [MANT_W-1:0]        mant_n;
    logic                     guard;
    logic                     sticky;
    logic                     round_up;
    logic [MANT_R_W-1:0]      mant_r;
    logic signed [EXPI_W-1:0] exp_n;
    logic signed [EXPI_W-1:0] exp_r;
    logic [FRAC_W-1:0]        frac_r;
    fp32_t                    s2_res_c;
    logic [FLAG_W-1:0]        s2_flags_c;

    // S2 registers
    fp32_t             s2_res;
    logic [FLAG_W-1:0] s2_flags;
    logic [ID_W-1:0]   s2_id;

    // S3 registers
    logic [WORD_W-1:0] s3_word;
    logic [FLAG_W-1:0] s3_flags;
    logic [ID_W-1:0]   s3_id;

    // A stage moves when it is empty or its successor moves
    always_comb begin
        adv3 = !v3 || bus.rsp_ready;
        adv2 = !v2 || adv3;
        adv1 = !v1 || adv2;
    end

    assign bus.req_ready = adv1 && !rst;

    fp32_classify u_cls_a (
        .op     (bus.req_a),
        .cls_c  (cls_a),
        .sign_c (sign_a),
        .exp_c  (exp_a),
        .mant_c (mant_a)
    );

    fp32_classify u_cls_b (
        .op     (bus.req_b),
        .cls_c  (cls_b),
        .sign_c (sign_b),
        .exp_c  (exp_b),
        .mant_c (mant_b)
    );

    // S1: special-case resolution, exponent sum and mantissa product
    always_comb begin
        sign_c       = sign_a ^ sign_b;
        spec_c       = 1'b1;
        spec_res_c   = fp32_t'(CANON_NAN);
        spec_flags_c = '0;
        if (cls_a == CLS_SNAN || cls_b == CLS_SNAN ||
            (cls_a == CLS_INF && cls_b == CLS_ZERO) ||
            (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
            spec_flags_c[FLAG_INVALID] = 1'b1;
        end else if (cls_a == CLS_QNAN || cls_b == CLS_QNAN) begin
            spec_res_c = fp32_t'(CANON_NAN);
        end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
            spec_res_c = '{sign: sign_c, expo: '1, frac: '0};
        end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
            spec_res_c = '{sign: sign_c, expo: '0, frac: '0};
        end else begin
            spec_c = 1'b0;
        end
        exp_sum_c = EXPI_W'(exp_a) + EXPI_W'(exp_b) - EXPI_W'(BIAS);
        prod_c    = PROD_W'(mant_a) * PROD_W'(mant_b);
    end

    // S2: normalise the [1,4) product, round to nearest even, range check
    always_comb begin
        norm_hi = s1_prod[PROD_W-1];
        if (norm_hi) begin
            mant_n = s1_prod[PROD_W-1 -: MANT_W];
            guard  = s1_prod[PROD_W-1-MANT_W];
            sticky = |s1_prod[PROD_W-2-MANT_W:0];
        end else begin
            mant_n = s1_prod[PROD_W-2 -: MANT_W];
            guard  = s1_prod[PROD_W-2-MANT_W];
            sticky = |s1_prod[PROD_W-3-MANT_W:0];
        end
        exp_n    = s1_exp + EXPI_W'(norm_hi);
        round_up = guard && (sticky || mant_n[0]);
        mant_r   = {1'b0, mant_n} + MANT_R_W'(round_up);
        // a rounding carry leaves 1.000..., so only the exponent moves
        exp_r    = exp_n + EXPI_W'(mant_r[MANT_W]);
        frac_r   = mant_r[MANT_W] ? mant_r[MANT_W-1:1] : mant_r[FRAC_W-1:0];

        s2_res_c   = '{sign: s1_sign, expo: exp_r[EXP_W-1:0], frac: frac_r};
        s2_flags_c = '0;
        s2_flags_c[FLAG_INEXACT] = guard || sticky;

        if (s1_special) begin
            s2_res_c   = s1_spec_res;
            s2_flags_c = s1_spec_flags;
        end else if (exp_r >= EXP_INF) begin
            s2_res_c = '{sign: s1_sign, expo: '1, frac: '0};
            s2_flags_c[FLAG_OVERFLOW] = 1'b1;
            s2_flags_c[FLAG_INEXACT]  = 1'b1;
        end else if (exp_r <= EXP_ZERO) begin
            s2_res_c = '{sign: s1_sign, expo: '0, frac: '0};
            s2_flags_c[FLAG_UNDERFLOW] = 1'b1;
            s2_flags_c[FLAG_INEXACT]   = 1'b1;
        end
    end

    // Stage valid bits: the only reset state
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (adv1) v1 <= bus.req_valid;
            if (adv2) v2 <= v1;
            if (adv3) v3 <= v2;
        end
    end

    // Datapath registers, loaded whenever their stage advances
    always_ff @(posedge clk) begin
        if (adv1) begin
            s1_special    <= spec_c;
            s1_spec_res   <= spec_res_c;
            s1_spec_flags <= spec_flags_c;
            s1_sign       <= sign_c;
            s1_exp        <= exp_sum_c;
            s1_prod       <= prod_c;
            s1_id         <= bus.req_id;
        end
        if (adv2) begin
            s2_res   <= s2_res_c;
            s2_flags <= s2_flags_c;
            s2_id    <= s1_id;
        end
        if (adv3) begin
            s3_word  <= s2_res;
            s3_flags <= s2_flags;
            s3_id    <= s2_id;
        end
    end

    // Response fields read as zero whenever no result is presented
    always_comb begin
        bus.rsp_valid  = v3;
        bus.rsp_result = v3 ? s3_word  : '0;
        bus.rsp_id     = v3 ? s3_id    : '0;
        bus.rsp_flags  = v3 ? s3_flags : '0;
    end

endmodule
